// File: rtl/mem_access_stage.sv
// MIPS MEM stage: store-data forwarding mux, word-addressed data memory,
// MEM/WB pipeline latch, sticky misalignment flag and saturating store counter.
module mem_access_stage #(
    parameter int          DEPTH  = 256,
    parameter int          ADDR_W = 8,
    parameter logic [5:0]  LW_OP  = 6'h23,
    parameter logic [5:0]  SW_OP  = 6'h2B
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [5:0]  exmem_op,
    input  logic [31:0] exmem_alu,
    input  logic [31:0] exmem_store_data,
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_regwrite,
    input  logic [1:0]  fwd_sel,
    input  logic [31:0] memwb_fwd_data,
    input  logic [31:0] after_fwd_data,
    output logic [5:0]  memwb_op,
    output logic [4:0]  memwb_rd,
    output logic        memwb_regwrite,
    output logic [31:0] memwb_result,
    output logic        misalign_fault,
    output logic [15:0] store_count
);

    logic [31:0]       mem [0:DEPTH-1];
    logic [ADDR_W-1:0] idx;
    logic              aligned;
    logic              is_lw;
    logic              is_sw;
    logic              misaligned;
    logic              advance;
    logic              commit;
    logic [31:0]       store_mux;
    logic [31:0]       load_data;
    logic              unused_addr_bits;

    // Upper address bits are ignored: the word index wraps modulo DEPTH.
    assign idx              = exmem_alu[ADDR_W+1:2];
    assign unused_addr_bits = ^exmem_alu[31:ADDR_W+2];
    assign aligned          = (exmem_alu[1:0] == 2'b00);
    assign is_lw            = (exmem_op == LW_OP);
    assign is_sw            = (exmem_op == SW_OP);
    assign misaligned       = (is_lw || is_sw) && !aligned;
    assign advance          = !stall && !flush && !reset;
    assign commit           = advance && is_sw && aligned;
    assign load_data        = mem[idx];

    always_comb begin
        store_mux = exmem_store_data;
        case (fwd_sel)
            2'd1:    store_mux = memwb_fwd_data;
            2'd2:    store_mux = after_fwd_data;
            default: store_mux = exmem_store_data;
        endcase
    end

    // Memory array has no reset; contents survive a pipeline reset.
    always_ff @(posedge clock) begin
        if (commit) begin
            mem[idx] <= store_mux;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            memwb_op       <= 6'd0;
            memwb_rd       <= 5'd0;
            memwb_regwrite <= 1'b0;
            memwb_result   <= 32'd0;
        end else if (flush) begin
            memwb_op       <= 6'd0;
            memwb_rd       <= 5'd0;
            memwb_regwrite <= 1'b0;
            memwb_result   <= 32'd0;
        end else if (!stall) begin
            memwb_op       <= exmem_op;
            memwb_rd       <= exmem_rd;
            memwb_regwrite <= exmem_regwrite && !misaligned;
            memwb_result   <= is_lw ? load_data : exmem_alu;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            misalign_fault <= 1'b0;
            store_count    <= 16'd0;
        end else begin
            if (advance && misaligned) begin
                misalign_fault <= 1'b1;
            end
            if (commit && (store_count != 16'hFFFF)) begin
                store_count <= store_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a table of directed vectors checked through an
// expected-result queue, then a long saturating-counter run against a memory model.
module tb_mem_access_stage;

    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] SW  = 6'h2B;
    localparam logic [5:0] ADD = 6'h20;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [5:0]  exmem_op;
    logic [31:0] exmem_alu;
    logic [31:0] exmem_store_data;
    logic [4:0]  exmem_rd;
    logic        exmem_regwrite;
    logic [1:0]  fwd_sel;
    logic [31:0] memwb_fwd_data;
    logic [31:0] after_fwd_data;
    logic [5:0]  memwb_op;
    logic [4:0]  memwb_rd;
    logic        memwb_regwrite;
    logic [31:0] memwb_result;
    logic        misalign_fault;
    logic [15:0] store_count;

    int checks   = 0;
    int failures = 0;

    mem_access_stage dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .exmem_op         (exmem_op),
        .exmem_alu        (exmem_alu),
        .exmem_store_data (exmem_store_data),
        .exmem_rd         (exmem_rd),
        .exmem_regwrite   (exmem_regwrite),
        .fwd_sel          (fwd_sel),
        .memwb_fwd_data   (memwb_fwd_data),
        .after_fwd_data   (after_fwd_data),
        .memwb_op         (memwb_op),
        .memwb_rd         (memwb_rd),
        .memwb_regwrite   (memwb_regwrite),
        .memwb_result     (memwb_result),
        .misalign_fault   (misalign_fault),
        .store_count      (store_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  fs;
        logic [31:0] mf;
        logic [31:0] af;
        logic        st;
        logic        fl;
        logic [60:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [60:0] exp_q[$];
    logic [31:0] ref_mem [0:255];

    function automatic vec_t mk(logic rst, logic [5:0] op, logic [31:0] alu, logic [31:0] sd,
                                logic [4:0] rd, logic rw, logic [1:0] fs, logic [31:0] mf,
                                logic [31:0] af, logic st, logic fl,
                                logic [5:0] e_op, logic [4:0] e_rd, logic e_rw,
                                logic [31:0] e_res, logic e_fault, logic [15:0] e_cnt);
        vec_t v;
        v.rst = rst; v.op = op; v.alu = alu; v.sd = sd; v.rd = rd; v.rw = rw;
        v.fs = fs; v.mf = mf; v.af = af; v.st = st; v.fl = fl;
        v.exp = {e_op, e_rd, e_rw, e_res, e_fault, e_cnt};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic rst, input logic [5:0] op, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                         input logic [1:0] fs, input logic [31:0] mf, input logic [31:0] af,
                         input logic st, input logic fl);
        reset = rst; exmem_op = op; exmem_alu = alu; exmem_store_data = sd;
        exmem_rd = rd; exmem_regwrite = rw; fwd_sel = fs;
        memwb_fwd_data = mf; after_fwd_data = af; stall = st; flush = fl;
        @(posedge clock);
        #1;
    endtask

    task automatic apply(input vec_t v, input int n);
        logic [60:0] e;
        exp_q.push_back(v.exp);
        drive(v.rst, v.op, v.alu, v.sd, v.rd, v.rw, v.fs, v.mf, v.af, v.st, v.fl);
        e = exp_q.pop_front();
        check($sformatf("vec%0d {op,rd,rw,result,fault,count}", n),
              {3'b0, memwb_op, memwb_rd, memwb_regwrite, memwb_result, misalign_fault, store_count},
              {3'b0, e});
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  w;
        // reset state
        vecs.push_back(mk(1, SW,  32'h10,  32'h1,        0, 0, 0, 0, 0, 0, 0,  6'h0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk(1, 0,   32'h0,   32'h0,        0, 0, 0, 0, 0, 0, 0,  6'h0, 0, 0, 32'h0, 0, 0));
        // store then load back, forwarding selects
        vecs.push_back(mk(0, SW,  32'h10,  32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0,  SW,  0, 0, 32'h10, 0, 1));
        vecs.push_back(mk(0, LW,  32'h10,  32'h0,        8, 1, 0, 0, 0, 0, 0,  LW,  8, 1, 32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(0, SW,  32'h20,  32'hFFFF,     0, 0, 1, 32'h1234, 32'h9, 0, 0, SW, 0, 0, 32'h20, 0, 2));
        vecs.push_back(mk(0, SW,  32'h24,  32'hFFFF,     0, 0, 2, 32'h9, 32'h5678, 0, 0, SW, 0, 0, 32'h24, 0, 3));
        vecs.push_back(mk(0, LW,  32'h20,  32'h0,        9, 1, 0, 0, 0, 0, 0,  LW,  9, 1, 32'h1234, 0, 3));
        vecs.push_back(mk(0, LW,  32'h24,  32'h0,       10, 1, 0, 0, 0, 0, 0,  LW, 10, 1, 32'h5678, 0, 3));
        vecs.push_back(mk(0, SW,  32'h28,  32'hCAFE0003, 0, 0, 3, 32'h1111, 32'h2222, 0, 0, SW, 0, 0, 32'h28, 0, 4));
        vecs.push_back(mk(0, LW,  32'h28,  32'h0,       11, 1, 0, 0, 0, 0, 0,  LW, 11, 1, 32'hCAFE0003, 0, 4));
        // address wrap: 0x400 is word 256 -> index 0
        vecs.push_back(mk(0, SW,  32'h400, 32'hA5,       0, 0, 0, 0, 0, 0, 0,  SW,  0, 0, 32'h400, 0, 5));
        vecs.push_back(mk(0, LW,  32'h0,   32'h0,       12, 1, 0, 0, 0, 0, 0,  LW, 12, 1, 32'hA5, 0, 5));
        // misaligned store: no write, regwrite forced low, fault sticks
        vecs.push_back(mk(0, SW,  32'h402, 32'hBAD,      7, 1, 0, 0, 0, 0, 0,  SW,  7, 0, 32'h402, 1, 5));
        vecs.push_back(mk(0, LW,  32'h400, 32'h0,       13, 1, 0, 0, 0, 0, 0,  LW, 13, 1, 32'hA5, 1, 5));
        vecs.push_back(mk(0, ADD, 32'h111, 32'h0,        1, 1, 0, 0, 0, 0, 0,  ADD, 1, 1, 32'h111, 1, 5));
        vecs.push_back(mk(0, ADD, 32'h222, 32'h0,        2, 1, 0, 0, 0, 0, 0,  ADD, 2, 1, 32'h222, 1, 5));
        vecs.push_back(mk(0, LW,  32'h10,  32'h0,        3, 1, 0, 0, 0, 0, 0,  LW,  3, 1, 32'hDEADBEEF, 1, 5));
        vecs.push_back(mk(0, SW,  32'h2C,  32'h0BADF00D, 0, 0, 0, 0, 0, 0, 0,  SW,  0, 0, 32'h2C, 1, 6));
        vecs.push_back(mk(0, ADD, 32'h333, 32'h0,        4, 1, 0, 0, 0, 0, 0,  ADD, 4, 1, 32'h333, 1, 6));
        // misaligned load: reads the containing word but never writes back
        vecs.push_back(mk(0, LW,  32'h13,  32'h0,       14, 1, 0, 0, 0, 0, 0,  LW, 14, 0, 32'hDEADBEEF, 1, 6));
        // stall holds MEM/WB, then releases
        vecs.push_back(mk(0, ADD, 32'h5555, 32'h0,       3, 1, 0, 0, 0, 0, 0,  ADD, 3, 1, 32'h5555, 1, 6));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, ADD, 32'hABCD, 32'h0,   5, 1, 0, 0, 0, 1, 0,  ADD, 3, 1, 32'h5555, 1, 6));
        vecs.push_back(mk(0, ADD, 32'hABCD, 32'h0,       5, 1, 0, 0, 0, 0, 0,  ADD, 5, 1, 32'hABCD, 1, 6));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, SW, 32'h40, 32'h77,     0, 0, 0, 0, 0, 1, 0,  ADD, 5, 1, 32'hABCD, 1, 6));
        vecs.push_back(mk(0, SW,  32'h40,  32'h77,       0, 0, 0, 0, 0, 0, 0,  SW,  0, 0, 32'h40, 1, 7));
        vecs.push_back(mk(0, LW,  32'h40,  32'h0,        6, 1, 0, 0, 0, 0, 0,  LW,  6, 1, 32'h77, 1, 7));
        // flush beats stall: bubble, no write
        vecs.push_back(mk(0, SW,  32'h44,  32'h11,       0, 0, 0, 0, 0, 0, 0,  SW,  0, 0, 32'h44, 1, 8));
        vecs.push_back(mk(0, SW,  32'h44,  32'h99,       9, 1, 0, 0, 0, 1, 1,  6'h0, 0, 0, 32'h0, 1, 8));
        vecs.push_back(mk(0, LW,  32'h44,  32'h0,        7, 1, 0, 0, 0, 0, 0,  LW,  7, 1, 32'h11, 1, 8));
        // reset during a store: no write, everything cleared
        vecs.push_back(mk(0, SW,  32'h48,  32'h22,       0, 0, 0, 0, 0, 0, 0,  SW,  0, 0, 32'h48, 1, 9));
        vecs.push_back(mk(1, SW,  32'h48,  32'h33,       0, 0, 0, 0, 0, 1, 1,  6'h0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, LW,  32'h48,  32'h0,        8, 1, 0, 0, 0, 0, 0,  LW,  8, 1, 32'h22, 0, 0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Saturation run against a reference memory.
        for (int i = 0; i < 70000; i++) begin
            d = $urandom;
            w = 8'($urandom_range(0, 255));
            ref_mem[w] = d;
            drive(0, SW, {22'($urandom_range(0, 1023)), w, 2'b00}, d, 0, 0, 0, 0, 0, 0, 0);
            if (i == 65533) check("count_before_saturation", 64'(store_count), 64'h0000_FFFE);
            if (i == 65534) check("count_at_saturation", 64'(store_count), 64'h0000_FFFF);
        end
        check("count_saturated_after_70000", 64'(store_count), 64'h0000_FFFF);
        check("fault_clear_after_clean_stores", 64'(misalign_fault), 64'h0);
        for (int k = 0; k < 6; k++) begin
            w = 8'($urandom_range(0, 255));
            if (ref_mem[w] === 32'bx) continue;
            drive(0, LW, {22'd0, w, 2'b00}, 32'h0, 5'd20, 1, 0, 0, 0, 0, 0);
            check($sformatf("readback_word_%0d", w), 64'(memwb_result), 64'(ref_mem[w]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MIPS pipeline MEM stage. Consumes the EX/MEM latch and the 2-bit store-data forwarding select produced by the memory forwarding unit.
- Performs the data-memory access for LW/SW and registers the MEM/WB pipeline latch.
- Feeds writeback and supplies the forwarding sources for later instructions.

Parameters:
- DEPTH, 256, data memory size in 32-bit words (power of two).
- ADDR_W, 8, word-index width, log2(DEPTH).
- LW_OP, 6'h23, load-word opcode.
- SW_OP, 6'h2B, store-word opcode.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold MEM/WB latch; suppress memory write.
- flush  in  1  insert bubble into MEM/WB; suppress memory write.
- exmem_op  in  6  opcode in EX/MEM.
- exmem_alu  in  32  ALU result / byte address.
- exmem_store_data  in  32  rt value latched in EX/MEM.
- exmem_rd  in  5  destination register.
- exmem_regwrite  in  1  destination write enable.
- fwd_sel  in  2  store-data select from forwarding unit: 0 = latch, 1 = MEM/WB value, 2 = later-stage value.
- memwb_fwd_data  in  32  value currently being written back.
- after_fwd_data  in  32  value from the stage after writeback.
- memwb_op  out  6  registered opcode.
- memwb_rd  out  5  registered destination.
- memwb_regwrite  out  1  registered write enable.
- memwb_result  out  32  load data for LW, else ALU result.
- misalign_fault  out  1  sticky misaligned-access flag.
- store_count  out  16  committed-store counter, saturating.

Behaviour:
- Reset, synchronous: memwb_op, memwb_rd and memwb_result = 0; memwb_regwrite = 0; misalign_fault = 0; store_count = 0. Memory array contents are not cleared.
- Word index = exmem_alu[ADDR_W+1:2]. Upper address bits are ignored, so the address wraps modulo DEPTH words.
- Aligned means exmem_alu[1:0] == 0. Only LW_OP and SW_OP are checked for alignment.
- Store data mux, combinational:
  - fwd_sel 0 selects exmem_store_data.
  - fwd_sel 1 selects memwb_fwd_data.
  - fwd_sel 2 selects after_fwd_data.
  - fwd_sel 3 is treated as 0.
- Write commit: mem[idx] is written with the mux output at the rising edge when all of these hold: op == SW_OP, aligned, !stall, !flush, !reset. Each commit increments store_count, which saturates at 16'hFFFF.
- Read: combinational from mem[idx]. A SW that commits at edge N is visible to a LW in EX/MEM during cycle N+1. There is no same-cycle write-through.
- MEM/WB latch update at each edge, in priority order:
  - reset, as above;
  - else flush: load a bubble (op = 0, rd = 0, regwrite = 0, result = 0). Flush wins over stall;
  - else stall: hold all MEM/WB outputs;
  - else load exmem_op, exmem_rd and exmem_regwrite, with result = load data for LW_OP, else exmem_alu.
- Misaligned LW or SW (not stalled, not flushed):
  - no memory write;
  - MEM/WB is loaded with regwrite forced to 0;
  - misalign_fault is set and stays at 1 until reset.
- Latency:
  - store is architecturally complete 1 edge after entering MEM;
  - load data appears on memwb_result 1 edge after entering MEM.
- Reset asserted mid-stall or mid-flush: reset dominates. No write occurs on that edge.

Test Plan:
- SW with alu=0x10, fwd_sel=0, store_data=0xDEADBEEF; next cycle LW with alu=0x10, rd=8 -> memwb_result=0xDEADBEEF, memwb_rd=8, memwb_regwrite=1, store_count=1.
- SW with alu=0x20, fwd_sel=1, memwb_fwd_data=0x1234, store_data=0xFFFF; then SW with alu=0x24, fwd_sel=2, after_fwd_data=0x5678; then LW from 0x20 and LW from 0x24 -> results 0x1234 and 0x5678. Repeat with fwd_sel=3 -> stored value is store_data.
- SW with alu=0x402 (misaligned) -> no write (a LW from 0x400 returns the prior value), misalign_fault=1 and remains 1 through 5 further clean ops, store_count unchanged, memwb_regwrite=0.
- ADD result 0xABCD with stall=1 for 3 cycles, then released -> MEM/WB holds the prior contents during the stall; the SW is held off, then commits once on release; memwb_result=0xABCD one edge after release.
- flush=1 and stall=1 together on a SW -> MEM/WB becomes a bubble (all zeros), memory unchanged, store_count unchanged.
- Wrap-around, DEPTH=256: SW alu=0x400 with data 0xA5; LW alu=0x0 -> 0xA5.
- 70000 committed stores -> store_count=0xFFFF.
- Assert reset during a SW -> no write; all outputs 0 on the next edge.
